ldpc_3gpp_dec_buffer_ctrl: RTL and testbench
============================================

# ldpc_3gpp_dec_buffer_ctrl

Bank-state controller for the decoder's multi-bank input LLR buffer. It sits between the input-source stage, which writes one frame per bank and pulses end-of-frame, and the decoder engine, which reads a full bank and releases it. It tracks bank occupancy, hands out write and read bank indexes, and stores one code context per bank. It produces the empty and full status flags that drive the source stage's ready/busy handshake.

## Interface

Parameters:
- pBNUM_W, 1: bank-index width; the buffer has NB = 2^pBNUM_W banks. Legal values are 1..3.
- pCTX_W, 32: width of the per-bank code context word.

Ports:
- iclk  in  1  clock.
- ireset  in  1  reset, synchronous, active-low; sampled on the rising edge of iclk and not gated by iclkena.
- iclkena  in  1  clock enable; when low, all state holds.
- iwfull  in  1  single-cycle pulse: the current write bank is completely written.
- iwctx  in  pCTX_W  code context of the frame; sampled together with iwfull.
- irempty  in  1  single-cycle pulse: the decoder has finished the current read bank and releases it.
- owbank  out  pBNUM_W  bank index the source stage writes into.
- orbank  out  pBNUM_W  bank index the decoder reads from.
- orval  out  1  at least one full bank is available to the decoder.
- orctx  out  pCTX_W  context stored for bank orbank.
- oempty  out  1  no bank holds a frame (cnt == 0).
- oemptya  out  1  almost empty (cnt <= 1).
- ofull  out  1  all banks hold frames (cnt == NB).
- ofulla  out  1  almost full (cnt >= NB-1).
- oovf  out  1  sticky error: iwfull arrived while ofull was high.
- ounf  out  1  sticky error: irempty arrived while oempty was high.

## Operation

Internal state:
- wptr, rptr: pBNUM_W bits each; they wrap naturally modulo NB.
- cnt: pBNUM_W+1 bits, range 0..NB.
- ctx_mem: NB × pCTX_W register array.

Events (all qualified by iclkena):
- wr = iwfull & !ofull.
- rd = irempty & !oempty.

On wr:
- ctx_mem[wptr] <= iwctx.
- wptr <= wptr+1.

On rd:
- rptr <= rptr+1.

Counter update:
- wr & !rd: cnt+1.
- rd & !wr: cnt-1.
- wr & rd: cnt unchanged, and both pointers advance.

Errors:
- iwfull & ofull: the write is dropped (no pointer, count or context change) and oovf <= 1.
- irempty & oempty: the release is dropped and ounf <= 1.
- oovf and ounf clear only on reset.

Outputs:
- owbank = wptr and orbank = rptr, both direct from registers.
- orctx = ctx_mem[rptr], a combinational mux of registers.
- orval = !oempty.

Flag rules:
- Flags are registered and computed from the next value of cnt, so each flag is exact in the cycle after the event.
- NB = 2: ofulla is high when cnt >= 1, and oemptya is high when cnt <= 1.

Reset (ireset low at a clock edge, with or without iclkena):
- wptr = rptr = 0, cnt = 0, oovf = ounf = 0.
- oempty = 1, oemptya = 1, ofull = 0.
- ofulla = 1 if NB-1 == 0, otherwise 0. Since NB >= 2, ofulla = 0.
- orval = 0, owbank = 0, orbank = 0.
- ctx_mem is not reset, so orctx is don't-care while orval = 0.
- Reset mid-operation discards every stored frame immediately; pulses arriving in the reset cycle are ignored.

## Timing

- Pulse-to-output latency is 1 cycle:
  - iwfull sampled at edge N gives an updated owbank, cnt and flags from edge N onward.
  - orval rises in the cycle after the iwfull pulse when the buffer was empty.
- irempty at edge N gives an updated orbank and orctx (the next bank's context) in the cycle after N.
- A back-to-back iwfull on consecutive cycles is legal; each pulse is accepted while !ofull.
- With iclkena low, pulses are ignored and not queued; the upstream logic must hold off.
- The source stage must not write after ofulla is high with its last free bank in use. It uses ofulla and ofull for ready.
- The block needs no handshake beyond the flags.

## Test plan

- Reset: with ireset = 0 for 2 cycles, then 1 → oempty = 1, oemptya = 1, ofull = 0, ofulla = 0, orval = 0, owbank = 0, orbank = 0, oovf = 0, ounf = 0.
- Single frame, NB = 2: iwfull with iwctx = 0xA5A5_0001 → next cycle orval = 1, owbank = 1, orctx = 0xA5A5_0001, ofulla = 1, oempty = 0. Then irempty → oempty = 1, orbank = 1.
- Overflow, NB = 2: 3 iwfull pulses with contexts 1, 2, 3 → ofull = 1 after the 2nd pulse. The 3rd pulse sets oovf = 1 and leaves wptr = 0. Two irempty pulses then read orctx = 1, then 2.
- Simultaneous events, NB = 4, cnt = 1: iwfull and irempty in the same cycle → cnt stays 1, wptr = 2, rptr = 1, flags unchanged, orctx = the context of the 2nd frame.
- Wrap-around, NB = 4: 10 write/release pairs with interleaved occupancy of 0..4 → pointers wrap from 3 to 0, orctx matches the write order every time, and no error flags are set.
- Gating, underflow and mid-operation reset:
  - irempty while empty → ounf = 1.
  - iwfull with iclkena = 0 → no change.
  - Reset asserted at cnt = 3 → all reset values are restored the next cycle.

Source files
------------

// File: rtl/ldpc_3gpp_dec_buffer_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ldpc_3gpp_dec_buffer_ctrl
// Description : Bank-state controller for the multi-bank input LLR buffer.
//               Tracks bank occupancy between the input-source stage (writer)
//               and the decoder engine (reader), hands out write/read bank
//               indexes, keeps one code context per bank and produces the
//               registered empty/full status flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ldpc_3gpp_dec_buffer_ctrl #(
    parameter int pBNUM_W = 1,
    parameter int pCTX_W  = 32
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic                iwfull,
    input  logic [pCTX_W-1:0]   iwctx,
    input  logic                irempty,
    output logic [pBNUM_W-1:0]  owbank,
    output logic [pBNUM_W-1:0]  orbank,
    output logic                orval,
    output logic [pCTX_W-1:0]   orctx,
    output logic                oempty,
    output logic                oemptya,
    output logic                ofull,
    output logic                ofulla,
    output logic                oovf,
    output logic                ounf
);

    localparam int             c_NB       = 1 << pBNUM_W;
    localparam logic [pBNUM_W:0] c_NB_CNT   = (pBNUM_W+1)'(c_NB);
    localparam logic [pBNUM_W:0] c_NBM1_CNT = (pBNUM_W+1)'(c_NB - 1);
    localparam logic [pBNUM_W:0] c_ONE_CNT  = (pBNUM_W+1)'(1);

    logic [pBNUM_W-1:0] r_wptr;
    logic [pBNUM_W-1:0] r_rptr;
    logic [pBNUM_W:0]   r_cnt;
    logic [pCTX_W-1:0]  r_ctx_mem [c_NB];

    logic               r_empty;
    logic               r_emptya;
    logic               r_full;
    logic               r_fulla;
    logic               r_ovf;
    logic               r_unf;

    logic               w_wr;
    logic               w_rd;
    logic [pBNUM_W:0]   w_cnt_nxt;

    // Accepted events: a pulse is dropped when its side is saturated
    assign w_wr = iclkena & iwfull  & ~r_full;
    assign w_rd = iclkena & irempty & ~r_empty;

    // Next occupancy; simultaneous write and release cancel out
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr && !w_rd) begin
            w_cnt_nxt = r_cnt + c_ONE_CNT;
        end else if (w_rd && !w_wr) begin
            w_cnt_nxt = r_cnt - c_ONE_CNT;
        end
    end

    // Pointers, occupancy, flags (from next count) and sticky error bits
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b1;
            r_emptya <= 1'b1;
            r_full   <= 1'b0;
            r_fulla  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (iclkena) begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt    <= w_cnt_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            r_emptya <= (w_cnt_nxt <= c_ONE_CNT);
            r_full   <= (w_cnt_nxt == c_NB_CNT);
            r_fulla  <= (w_cnt_nxt >= c_NBM1_CNT);
            if (iwfull && r_full) begin
                r_ovf <= 1'b1;
            end
            if (irempty && r_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Context storage; contents are meaningless until a bank is written
    always_ff @(posedge iclk) begin
        if (ireset && w_wr) begin
            r_ctx_mem[r_wptr] <= iwctx;
        end
    end

    assign owbank  = r_wptr;
    assign orbank  = r_rptr;
    assign orctx   = r_ctx_mem[r_rptr];
    assign orval   = ~r_empty;
    assign oempty  = r_empty;
    assign oemptya = r_emptya;
    assign ofull   = r_full;
    assign ofulla  = r_fulla;
    assign oovf    = r_ovf;
    assign ounf    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_3gpp_dec_buffer_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ldpc_3gpp_dec_buffer_ctrl
// Description : Scoreboard bench for the buffer controller. Two instances
//               (2 banks and 4 banks) see the same stimulus; a queue-based
//               frame model predicts every output after each clock edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ldpc_3gpp_dec_buffer_ctrl;

    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  rb;
        logic        val;
        logic        e;
        logic        ea;
        logic        f;
        logic        fa;
        logic        ovf;
        logic        unf;
        logic [31:0] ctx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wf = 1'b0;
    logic [31:0] wctx = '0;
    logic        re = 1'b0;

    logic [0:0]  wb0, rb0;
    logic [1:0]  wb1, rb1;
    logic [31:0] ctx0, ctx1;
    logic        val0, e0, ea0, f0, fa0, ovf0, unf0;
    logic        val1, e1, ea1, f1, fa1, ovf1, unf1;

    int total = 0;
    int bad   = 0;

    // reference model state: stored frames in order, pointer positions, errors
    logic [31:0] mq [2][$];
    int          mwp [2];
    int          mrp [2];
    logic        movf [2];
    logic        munf [2];
    exp_t        sb  [2][$];

    always #5 clk = ~clk;

    ldpc_3gpp_dec_buffer_ctrl #(.pBNUM_W(1), .pCTX_W(32)) u_dut2 (
        .iclk(clk), .ireset(rst_n), .iclkena(en), .iwfull(wf), .iwctx(wctx),
        .irempty(re), .owbank(wb0), .orbank(rb0), .orval(val0), .orctx(ctx0),
        .oempty(e0), .oemptya(ea0), .ofull(f0), .ofulla(fa0), .oovf(ovf0), .ounf(unf0)
    );

    ldpc_3gpp_dec_buffer_ctrl #(.pBNUM_W(2), .pCTX_W(32)) u_dut4 (
        .iclk(clk), .ireset(rst_n), .iclkena(en), .iwfull(wf), .iwctx(wctx),
        .irempty(re), .owbank(wb1), .orbank(rb1), .orval(val1), .orctx(ctx1),
        .oempty(e1), .oemptya(ea1), .ofull(f1), .ofulla(fa1), .oovf(ovf1), .ounf(unf1)
    );

    // advance model k by one clock edge and return the predicted outputs
    function automatic exp_t model_step(int k, logic r_n, logic ce, logic w,
                                        logic [31:0] c, logic r);
        int   nb = (k == 0) ? 2 : 4;
        int   n;
        exp_t x;
        if (!r_n) begin
            mq[k].delete();
            mwp[k] = 0; mrp[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
        end else if (ce) begin
            n = mq[k].size();
            if (w && n == nb) movf[k] = 1'b1;
            if (r && n == 0)  munf[k] = 1'b1;
            if (r && n > 0) begin
                void'(mq[k].pop_front());
                mrp[k] = (mrp[k] + 1) % nb;
            end
            if (w && n < nb) begin
                mq[k].push_back(c);
                mwp[k] = (mwp[k] + 1) % nb;
            end
        end
        n     = mq[k].size();
        x.wb  = 2'(mwp[k]);
        x.rb  = 2'(mrp[k]);
        x.val = (n > 0);
        x.e   = (n == 0);
        x.ea  = (n <= 1);
        x.f   = (n == nb);
        x.fa  = (n >= nb - 1);
        x.ovf = movf[k];
        x.unf = munf[k];
        x.ctx = (n > 0) ? mq[k][0] : 32'h0;
        return x;
    endfunction

    // drive one cycle of stimulus and queue the expected response
    task automatic cyc(logic r_n, logic ce, logic w, logic [31:0] c, logic r);
        @(negedge clk);
        rst_n = r_n; en = ce; wf = w; wctx = c; re = r;
        sb[0].push_back(model_step(0, r_n, ce, w, c, r));
        sb[1].push_back(model_step(1, r_n, ce, w, c, r));
    endtask

    task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL nb%0d %s: got %h expected %h at %0t", (k == 0) ? 2 : 4, nm, act, req, $time);
        end
    endtask

    // monitor: compare DUT outputs just after every edge that has a prediction
    initial begin
        exp_t x;
        exp_t a [2];
        forever begin
            @(posedge clk);
            #1;
            a[0] = {1'b0, wb0, 1'b0, rb0, val0, e0, ea0, f0, fa0, ovf0, unf0, ctx0};
            a[1] = {wb1, rb1, val1, e1, ea1, f1, fa1, ovf1, unf1, ctx1};
            for (int k = 0; k < 2; k++) begin
                if (sb[k].size() > 0) begin
                    x = sb[k].pop_front();
                    chk(k, "owbank",  32'(a[k].wb),  32'(x.wb));
                    chk(k, "orbank",  32'(a[k].rb),  32'(x.rb));
                    chk(k, "orval",   32'(a[k].val), 32'(x.val));
                    chk(k, "oempty",  32'(a[k].e),   32'(x.e));
                    chk(k, "oemptya", 32'(a[k].ea),  32'(x.ea));
                    chk(k, "ofull",   32'(a[k].f),   32'(x.f));
                    chk(k, "ofulla",  32'(a[k].fa),  32'(x.fa));
                    chk(k, "oovf",    32'(a[k].ovf), 32'(x.ovf));
                    chk(k, "ounf",    32'(a[k].unf), 32'(x.unf));
                    if (x.val) chk(k, "orctx", a[k].ctx, x.ctx);
                end
            end
        end
    end

    // stimulus: directed scenarios followed by randomized traffic
    initial begin
        // reset held for two cycles
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        // single frame then release
        cyc(1, 1, 1, 32'hA5A5_0001, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        // overflow on the 2-bank instance, then drain
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 32'd1, 0);
        cyc(1, 1, 1, 32'd2, 0);
        cyc(1, 1, 1, 32'd3, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        // simultaneous write and release at one stored frame
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 32'h1111_0001, 0);
        cyc(1, 1, 1, 32'h1111_0002, 1);
        cyc(1, 1, 0, 0, 0);
        // wrap-around: ten write/release pairs with varying occupancy
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j <= (i % 4); j++) cyc(1, 1, 1, 32'h2000_0000 + 32'(i * 8 + j), 0);
            for (int j = 0; j <= (i % 4); j++) cyc(1, 1, 0, 0, 1);
        end
        // underflow, gated write, mid-operation reset at three frames
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
        cyc(1, 1, 1, 32'h3000_0001, 0);
        cyc(1, 1, 1, 32'h3000_0002, 0);
        cyc(1, 1, 1, 32'h3000_0003, 0);
        cyc(0, 0, 1, 32'h3000_0004, 1);
        cyc(1, 1, 0, 0, 0);
        // randomized traffic with occasional gating and rare resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 40));
        end
        cyc(1, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0", sb[0].size(), sb[1].size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
